// File: rtl/phy_tx_pkg.sv
// Shared constants, state encoding and output symbol layout for the PHY TX lane scheduler.
package phy_tx_pkg;

    localparam int unsigned LANES         = 4;
    localparam int unsigned LANE_W        = 9;
    localparam logic [7:0]  IDLE_CHAR_DEF = 8'hBC;

    localparam logic [0:0] ST_SYNC   = 1'b0;
    localparam logic [0:0] ST_ACTIVE = 1'b1;

    typedef struct packed {
        logic [7:0] data;
        logic       k;
        logic       vld;
        logic [1:0] lane;
    } out_sym_t;

endpackage

// File: rtl/rr_arbiter4.sv
// Four-way round-robin grant: first requester at or above ptr, wrapping modulo 4.
// Purely combinational; one-hot grant plus any_grant.
module rr_arbiter4 (
    input  logic [3:0] req,
    input  logic [1:0] ptr,
    output logic [3:0] grant,
    output logic       any_grant
);

    logic [1:0] idx;

    always_comb begin
        grant     = '0;
        any_grant = 1'b0;
        idx       = '0;
        for (int i = 0; i < 4; i++) begin
            idx = ptr + 2'(i);
            if (!any_grant && req[idx]) begin
                grant[idx] = 1'b1;
                any_grant  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/phy_tx_lane_scheduler.sv
// Four-lane round-robin TX scheduler; sends SYNC_COUNT commas after reset/resync before data.
// Accepted byte appears one clock after its ready pulse; everything holds while out_ready is low.
module phy_tx_lane_scheduler
    import phy_tx_pkg::*;
#(
    parameter int unsigned SYNC_COUNT = 4,
    parameter logic [7:0]  IDLE_CHAR  = IDLE_CHAR_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [LANE_W-1:0] paralelo0,
    input  logic [LANE_W-1:0] paralelo1,
    input  logic [LANE_W-1:0] paralelo2,
    input  logic [LANE_W-1:0] paralelo3,
    output logic              ready0,
    output logic              ready1,
    output logic              ready2,
    output logic              ready3,
    input  logic              resync,
    input  logic              out_ready,
    output logic [7:0]        out_data,
    output logic              out_k,
    output logic              out_valid,
    output logic [1:0]        out_lane,
    output logic              active
);

    localparam int unsigned      CNT_W    = $clog2(SYNC_COUNT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SYNC_COUNT - 1);

    logic [0:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [1:0]        ptr_q, ptr_d;
    out_sym_t          out_q, out_d;

    logic [LANE_W-1:0] lane_word [LANES];
    logic [3:0]        req;
    logic [3:0]        grant;
    logic              any_grant;
    logic [1:0]        gnt_idx;
    logic [7:0]        gnt_byte;
    logic [3:0]        rdy;
    out_sym_t          idle_sym;

    assign lane_word[0] = paralelo0;
    assign lane_word[1] = paralelo1;
    assign lane_word[2] = paralelo2;
    assign lane_word[3] = paralelo3;

    always_comb begin
        req      = '0;
        gnt_idx  = '0;
        gnt_byte = '0;
        for (int i = 0; i < LANES; i++) begin
            req[i] = lane_word[i][LANE_W-1];
            if (grant[i]) begin
                gnt_idx  = 2'(i);
                gnt_byte = lane_word[i][7:0];
            end
        end
    end

    rr_arbiter4 u_arb (
        .req       (req),
        .ptr       (ptr_q),
        .grant     (grant),
        .any_grant (any_grant)
    );

    assign idle_sym = '{data: IDLE_CHAR, k: 1'b1, vld: 1'b1, lane: 2'd0};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        out_d   = out_q;
        rdy     = '0;
        // resync wins over everything, including a pending lane grant on the same edge
        if (resync) begin
            state_d = ST_SYNC;
            cnt_d   = '0;
            if (out_ready) begin
                out_d = idle_sym;
            end
        end else if (out_ready) begin
            if (state_q == ST_SYNC) begin
                out_d = idle_sym;
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_ACTIVE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end else if (any_grant) begin
                rdy   = grant;
                out_d = '{data: gnt_byte, k: 1'b0, vld: 1'b1, lane: gnt_idx};
                ptr_d = gnt_idx + 2'd1;
            end else begin
                out_d = idle_sym;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_SYNC;
            cnt_q   <= '0;
            ptr_q   <= '0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            out_q   <= out_d;
        end
    end

    assign {ready3, ready2, ready1, ready0} = rdy;
    assign out_data  = out_q.data;
    assign out_k     = out_q.k;
    assign out_valid = out_q.vld;
    assign out_lane  = out_q.lane;
    assign active    = (state_q == ST_ACTIVE);

endmodule

// File: tb/tb_phy_tx_lane_scheduler.sv
// Scoreboarded bench: driver predicts readies and the post-edge output register from the
// scheduling rules; an independent monitor pops and compares every cycle.
module tb_phy_tx_lane_scheduler;

    localparam int         SYNC_N = 4;
    localparam logic [7:0] IDLE   = 8'hBC;

    typedef struct packed {
        logic [7:0] data;
        logic       k;
        logic       vld;
        logic [1:0] lane;
        logic       act;
    } obs_t;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       resync = 1'b0;
    logic       out_ready = 1'b0;
    logic [8:0] par [4];
    logic       ready0, ready1, ready2, ready3;
    logic [7:0] out_data;
    logic       out_k, out_valid, active;
    logic [1:0] out_lane;

    int checks = 0;
    int failures = 0;

    obs_t       regq [$];
    logic [3:0] rdyq [$];

    bit   m_sync;
    int   m_commas;
    int   m_rr;
    obs_t m_reg;

    phy_tx_lane_scheduler #(.SYNC_COUNT(SYNC_N), .IDLE_CHAR(IDLE)) dut (
        .clk       (clk),
        .reset     (reset),
        .paralelo0 (par[0]),
        .paralelo1 (par[1]),
        .paralelo2 (par[2]),
        .paralelo3 (par[3]),
        .ready0    (ready0),
        .ready1    (ready1),
        .ready2    (ready2),
        .ready3    (ready3),
        .resync    (resync),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_k     (out_k),
        .out_valid (out_valid),
        .out_lane  (out_lane),
        .active    (active)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_sync   = 1'b1;
        m_commas = 0;
        m_rr     = 0;
        m_reg    = '0;
    endtask

    // One clock of stimulus; the model decides what the next edge must produce.
    task automatic cycle(input logic [8:0] w0, input logic [8:0] w1, input logic [8:0] w2,
                         input logic [8:0] w3, input logic ordy, input logic rs);
        logic [3:0] er;
        obs_t       idle_sym;
        int         found;
        @(negedge clk);
        par[0] = w0; par[1] = w1; par[2] = w2; par[3] = w3;
        out_ready = ordy;
        resync    = rs;
        er        = '0;
        idle_sym  = '{data: IDLE, k: 1'b1, vld: 1'b1, lane: 2'd0, act: 1'b0};
        if (rs) begin
            m_sync   = 1'b1;
            m_commas = 0;
            if (ordy) m_reg = idle_sym;
        end else if (ordy) begin
            if (m_sync) begin
                m_reg = idle_sym;
                m_commas++;
                if (m_commas == SYNC_N) begin
                    m_sync   = 1'b0;
                    m_commas = 0;
                end
            end else begin
                found = -1;
                for (int k = 0; k < 4; k++) begin
                    int l;
                    l = (m_rr + k) % 4;
                    if (found < 0 && par[l][8]) found = l;
                end
                if (found >= 0) begin
                    er[found] = 1'b1;
                    m_reg = '{data: par[found][7:0], k: 1'b0, vld: 1'b1, lane: 2'(found), act: 1'b0};
                    m_rr  = (found + 1) % 4;
                end else begin
                    m_reg = idle_sym;
                end
            end
        end
        m_reg.act = !m_sync;
        rdyq.push_back(er);
        regq.push_back(m_reg);
    endtask

    task automatic check_zero(input string nm);
        chk(nm, {19'd0, out_data, out_k, out_valid, out_lane, active},
            32'd0);
        chk({nm, "_ready"}, {28'd0, ready3, ready2, ready1, ready0}, 32'd0);
    endtask

    // Monitor: readies checked late in the cycle, register checked just after the edge.
    always begin
        logic [3:0] exp_r;
        obs_t       exp_o;
        @(negedge clk);
        #3;
        if (!reset && rdyq.size() > 0) begin
            exp_r = rdyq.pop_front();
            chk("ready_vec", {28'd0, ready3, ready2, ready1, ready0}, {28'd0, exp_r});
        end
        @(posedge clk);
        #1;
        if (!reset && regq.size() > 0) begin
            exp_o = regq.pop_front();
            chk("out_reg", {19'd0, out_data, out_k, out_valid, out_lane, active}, {19'd0, exp_o});
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 4; i++) par[i] = 9'h1AA;
        out_ready = 1'b1;
        model_reset();
        #1 reset = 1'b1;
        #1 check_zero("reset_state");
        repeat (2) @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        reset     = 1'b0;

        // Comma sync with all lanes invalid, then idles
        repeat (6) cycle(9'h000, 9'h000, 9'h000, 9'h000, 1'b1, 1'b0);
        // Pointer still 0: all four held valid go out in lane order
        repeat (4) cycle(9'h1FF, 9'h1F5, 9'h1FA, 9'h1F4, 1'b1, 1'b0);
        // Only lane 2 valid
        repeat (3) cycle(9'h0FF, 9'h0FF, 9'h1FF, 9'h055, 1'b1, 1'b0);
        // out_ready toggling
        for (int i = 0; i < 8; i++)
            cycle(9'h155, 9'h155, 9'h155, 9'h155, ((i % 2) == 0) || (i > 5), 1'b0);
        // Grant lane 1, then resync: commas, then lane 2 first
        cycle(9'h000, 9'h111, 9'h000, 9'h000, 1'b1, 1'b0);
        cycle(9'h1A0, 9'h1A1, 9'h1A2, 9'h1A3, 1'b1, 1'b1);
        repeat (6) cycle(9'h1A0, 9'h1A1, 9'h1A2, 9'h1A3, 1'b1, 1'b0);
        // resync while already syncing
        cycle(9'h000, 9'h000, 9'h000, 9'h000, 1'b1, 1'b1);
        repeat (2) cycle(9'h000, 9'h000, 9'h000, 9'h000, 1'b1, 1'b0);
        cycle(9'h000, 9'h000, 9'h000, 9'h000, 1'b0, 1'b1);
        repeat (6) cycle(9'h1C0, 9'h000, 9'h000, 9'h1C3, 1'b1, 1'b0);

        // Asynchronous reset between edges while a symbol is held
        @(posedge clk);
        #3;
        chk("pre_reset_valid", {31'd0, out_valid}, 32'd1);
        reset = 1'b1;
        #1 check_zero("mid_reset");
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        resync    = 1'b0;
        reset     = 1'b0;
        repeat (6) cycle(9'h1EE, 9'h000, 9'h000, 9'h000, 1'b1, 1'b0);

        // Randomized traffic with stalls and occasional resync
        for (int n = 0; n < 400; n++) begin
            logic [8:0] w [4];
            for (int i = 0; i < 4; i++)
                w[i] = {1'($urandom_range(0, 1)), 8'($urandom_range(0, 255))};
            cycle(w[0], w[1], w[2], w[3], ($urandom_range(0, 3) != 0), ($urandom_range(0, 40) == 0));
        end

        @(posedge clk);
        #2;
        chk("queue_drain", rdyq.size() + regq.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
